// File: rtl/pipeline_hazard_ctrl.sv
// Hazard sequencer for the 5-stage pipeline: PC enable, per-latch enable/flush, halt drain.
// Optional perf counters (stall_cnt/flush_cnt) are built when HAZARD_PERF_CNT_EN is defined.
module pipeline_hazard_ctrl #(
  parameter int DRAIN_CYCLES = 3
`ifdef HAZARD_PERF_CNT_EN
  ,
  parameter int CNT_W = 32
`endif
) (
  input  logic       CLK,
  input  logic       nRST,
  input  logic       ihit,
  input  logic       dhit,
  input  logic       mem_dreq,
  input  logic       ex_memrd,
  input  logic [4:0] ex_wsel,
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic       id_uses_rt,
  input  logic       ex_redirect,
  input  logic       id_halt,
  output logic       pc_en,
  output logic       fd_en,
  output logic       fd_flush,
  output logic       de_en,
  output logic       de_flush,
  output logic       em_en,
  output logic       em_flush,
  output logic       mw_en,
  output logic       mw_flush,
  output logic       halt_out
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
`endif
);

  localparam int DW = $clog2(DRAIN_CYCLES + 2);
  localparam logic [1:0] ST_RUN   = 2'd0;
  localparam logic [1:0] ST_DWAIT = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_HALT  = 2'd3;
  localparam logic [DW-1:0] DRAIN_INIT = DW'(DRAIN_CYCLES);

  function automatic logic load_use_hit(input logic memrd, input logic [4:0] wsel,
                                        input logic [4:0] rs, input logic [4:0] rt,
                                        input logic uses_rt);
    return memrd && (wsel != 5'd0) && ((wsel == rs) || (uses_rt && (wsel == rt)));
  endfunction

  logic [1:0]    state_r, state_nxt_s;
  logic [DW-1:0] dcnt_r, dcnt_nxt_s;
  logic          lu_r, lu_nxt_s;
  logic          halt_out_r;
  logic          dstall_s, lu_raw_s;
  logic          pc_en_s, fd_en_s, fd_flush_s, de_en_s, de_flush_s;
  logic          em_en_s, em_flush_s, mw_en_s, mw_flush_s;

  assign dstall_s = mem_dreq & ~dhit;
  assign lu_raw_s = load_use_hit(ex_memrd, ex_wsel, id_rs, id_rt, id_uses_rt);

  // Next-state and latch control; lu_r marks a dependence already served by its one stall cycle.
  always_comb begin
    pc_en_s     = 1'b1;
    fd_en_s     = 1'b1;
    fd_flush_s  = 1'b0;
    de_en_s     = 1'b1;
    de_flush_s  = 1'b0;
    em_en_s     = 1'b1;
    em_flush_s  = 1'b0;
    mw_en_s     = 1'b1;
    mw_flush_s  = 1'b0;
    state_nxt_s = state_r;
    dcnt_nxt_s  = dcnt_r;
    lu_nxt_s    = lu_r & lu_raw_s;
    case (state_r)
      ST_RUN, ST_DWAIT: begin
        if (dstall_s) begin
          pc_en_s     = 1'b0;
          fd_en_s     = 1'b0;
          de_en_s     = 1'b0;
          em_en_s     = 1'b0;
          mw_flush_s  = 1'b1;
          state_nxt_s = ST_DWAIT;
        end else if (ex_redirect) begin
          fd_flush_s  = 1'b1;
          de_flush_s  = 1'b1;
          state_nxt_s = ST_RUN;
        end else if (lu_raw_s && !lu_r) begin
          pc_en_s     = 1'b0;
          fd_en_s     = 1'b0;
          de_flush_s  = 1'b1;
          lu_nxt_s    = 1'b1;
          state_nxt_s = ST_RUN;
        end else if (!ihit) begin
          pc_en_s     = 1'b0;
          fd_en_s     = 1'b0;
          de_flush_s  = 1'b1;
          state_nxt_s = ST_RUN;
        end else if (id_halt) begin
          pc_en_s     = 1'b0;
          fd_flush_s  = 1'b1;
          de_flush_s  = 1'b1;
          dcnt_nxt_s  = DRAIN_INIT;
          state_nxt_s = ST_DRAIN;
        end else begin
          state_nxt_s = ST_RUN;
        end
      end
      ST_DRAIN: begin
        pc_en_s    = 1'b0;
        fd_flush_s = 1'b1;
        if (dstall_s) begin
          // EX is frozen here, so ID_EX must hold rather than be overwritten by a bubble.
          fd_en_s    = 1'b0;
          de_en_s    = 1'b0;
          em_en_s    = 1'b0;
          mw_flush_s = 1'b1;
        end else begin
          de_flush_s = 1'b1;
          if (dcnt_r <= DW'(1)) begin
            dcnt_nxt_s  = {DW{1'b0}};
            state_nxt_s = ST_HALT;
          end else begin
            dcnt_nxt_s = dcnt_r - DW'(1);
          end
        end
      end
      ST_HALT: begin
        pc_en_s = 1'b0;
        fd_en_s = 1'b0;
        de_en_s = 1'b0;
        em_en_s = 1'b0;
        mw_en_s = 1'b0;
      end
      default: begin
        pc_en_s     = 1'b0;
        fd_en_s     = 1'b0;
        de_en_s     = 1'b0;
        em_en_s     = 1'b0;
        mw_en_s     = 1'b0;
        state_nxt_s = ST_RUN;
      end
    endcase
  end

  // Sequencer state, drain counter and sticky halt flag.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_r    <= ST_RUN;
      dcnt_r     <= {DW{1'b0}};
      lu_r       <= 1'b0;
      halt_out_r <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      dcnt_r     <= dcnt_nxt_s;
      lu_r       <= lu_nxt_s;
      halt_out_r <= (state_nxt_s == ST_HALT);
    end
  end

  assign pc_en    = nRST & pc_en_s;
  assign fd_en    = nRST & fd_en_s;
  assign fd_flush = nRST & fd_flush_s;
  assign de_en    = nRST & de_en_s;
  assign de_flush = nRST & de_flush_s;
  assign em_en    = nRST & em_en_s;
  assign em_flush = nRST & em_flush_s;
  assign mw_en    = nRST & mw_en_s;
  assign mw_flush = nRST & mw_flush_s;
  assign halt_out = halt_out_r;

`ifdef HAZARD_PERF_CNT_EN
  logic             in_run_s, stall_inc_s, flush_inc_s;
  logic [CNT_W-1:0] stall_cnt_r, flush_cnt_r;

  assign in_run_s    = (state_r == ST_RUN) || (state_r == ST_DWAIT);
  assign stall_inc_s = in_run_s && !pc_en_s;
  assign flush_inc_s = in_run_s && !dstall_s && ex_redirect;

  // Saturating perf counters.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      stall_cnt_r <= {CNT_W{1'b0}};
      flush_cnt_r <= {CNT_W{1'b0}};
    end else begin
      if (stall_inc_s && (stall_cnt_r != {CNT_W{1'b1}})) begin
        stall_cnt_r <= stall_cnt_r + CNT_W'(1);
      end
      if (flush_inc_s && (flush_cnt_r != {CNT_W{1'b1}})) begin
        flush_cnt_r <= flush_cnt_r + CNT_W'(1);
      end
    end
  end

  assign stall_cnt = stall_cnt_r;
  assign flush_cnt = flush_cnt_r;
`endif

endmodule
